// File: rtl/calc_mem.sv
// Handshaked word memory with per-byte write enables, registered read response and a sequential clear engine.
// Optional per-word even parity is compiled in with `define CALC_MEM_PARITY_EN.
module calc_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic              err_inject,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned BE_W = DATA_W / 8;
`ifdef CALC_MEM_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned MEM_W = DATA_W + PAR_W;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [MEM_W-1:0]  mem [DEPTH];

  logic              accept_c;
  logic              in_range_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [MEM_W-1:0]  wr_word_c;
  logic [MEM_W-1:0]  rd_word_c;
  logic [DATA_W-1:0] merged_c;
  logic              par_err_c;

  assign busy       = (state == ST_CLEAR);
  assign req_ready  = (state == ST_RUN) && !clr && (!rsp_valid || rsp_ready);
  assign accept_c   = req_valid && req_ready;
  assign in_range_c = (ADDR_W+1)'(req_addr) < (ADDR_W+1)'(DEPTH);

  // Asynchronous array read feeds both the byte merge and the response register
  always_comb begin
    rd_word_c = '0;
    if (in_range_c) rd_word_c = mem[req_addr];
  end

  always_comb begin
    merged_c = rd_word_c[DATA_W-1:0];
    for (int i = 0; i < BE_W; i++) begin
      if (req_be[i]) merged_c[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

`ifdef CALC_MEM_PARITY_EN
  assign par_err_c = (^rd_word_c[DATA_W-1:0]) != rd_word_c[DATA_W];
`else
  logic unused_err_inject;
  assign unused_err_inject = err_inject;
  assign par_err_c         = 1'b0;
`endif

  // Single write port: the clear sweep owns it while busy, otherwise accepted in-range writes
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = clr_cnt;
    wr_word_c = '0;
    if (state == ST_CLEAR) begin
      wr_en_c = 1'b1;
    end else if (accept_c && req_rw && in_range_c) begin
      wr_en_c   = 1'b1;
      wr_addr_c = req_addr;
`ifdef CALC_MEM_PARITY_EN
      wr_word_c = {(^merged_c) ^ err_inject, merged_c};
`else
      wr_word_c = merged_c;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en_c) mem[wr_addr_c] <= wr_word_c;
  end

  // Control FSM and response register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state   <= ST_RUN;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          if (clr) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            rsp_valid <= 1'b0;
          end else if (accept_c && !req_rw) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= in_range_c ? rd_word_c[DATA_W-1:0] : '0;
            rsp_err   <= !in_range_c || par_err_c;
          end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: doc/calc_mem.md
# calc_mem

Parametrised, handshaked word memory for the calculator datapath, replacing the fixed 256×32 store. It accepts read and write requests over a valid/ready interface. Writes apply per-byte enables. Read data is returned through a response register with backpressure, so the tri-stated output bus is no longer needed. On reset, or on request, a sequential clear engine zeroes the whole array.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- ADDR_W, 8, address width
- DEPTH, 256, number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  synchronous, active-low reset
- clr  in  1  one-cycle pulse; starts a full-array clear
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_rw  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads
- err_inject  in  1  when high with an accepted write, stores the word with flipped parity; ignored unless parity is compiled in
- rsp_valid  out  1  read response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  response error flag
- busy  out  1  clear in progress

## Operation
- States:
  - CLEAR: a counter walks addresses 0..DEPTH-1, writing zero to one word per cycle. After address DEPTH-1 the block moves to RUN.
  - RUN: the block services requests.
  - Entering CLEAR: on reset low, or on clr high in RUN. clr is ignored while already in CLEAR (no restart).
- req_ready = (state==RUN) && !clr && (!rsp_valid || rsp_ready). It is combinational. A clr pulse and a request in the same cycle: clr wins and the request is not accepted.
- Accepted write:
  - Byte lane i of the word updates only if req_be[i]=1; lanes with req_be[i]=0 keep their old value.
  - A write with req_be all zero is a legal no-op.
  - No response is generated.
- Accepted read: the response register loads the word at req_addr, and rsp_valid rises.
- Out-of-range address (req_addr ≥ DEPTH):
  - A write is dropped and the array is unchanged.
  - A read still produces a response, with rsp_rdata=0 and rsp_err=1.
- The response register holds its values while rsp_valid && !rsp_ready. rsp_valid clears on handshake unless a new read is accepted in the same cycle; in that case the register reloads and rsp_valid stays high.
- Entering CLEAR drops any pending response: rsp_valid goes to 0.
- busy = (state==CLEAR).

## Timing
- Reset values, while reset is sampled low:
  - state=CLEAR, clear counter=0
  - busy=1, req_ready=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - Array contents are not directly reset; they are zeroed by the clear sweep.
- Clear length: the first cycle with reset high clears address 0. Address DEPTH-1 is cleared on cycle DEPTH. req_ready can first be high on cycle DEPTH+1. A clr pulse likewise costs exactly DEPTH cycles.
- Read latency: a read accepted at edge N gives rsp_valid=1 with data after edge N, i.e. one cycle.
- Back-to-back reads with rsp_ready held high sustain one response per cycle.
- Write-then-read to the same address on consecutive accepts returns the new data, with byte merge applied.
- A write and a pending response never conflict: the write does not alter a response that has already been loaded.
- Reset asserted mid-operation, at any cycle: the required outputs match the reset values on the next edge, and any in-flight request is discarded.

## Configuration
- CALC_MEM_PARITY_EN defined:
  - Each word stores one extra even-parity bit over DATA_W bits, recomputed after the byte merge.
  - With err_inject=1, the stored parity bit is inverted.
  - Clear stores zero with parity 0.
  - A read whose recomputed parity mismatches returns the stored data unchanged with rsp_err=1.
- CALC_MEM_PARITY_EN undefined:
  - No parity storage.
  - err_inject is ignored.
  - rsp_err is set only for out-of-range reads.

## Test plan
- Reset low for 3 cycles, then high:
  - busy=1 and req_ready=0 for exactly 256 cycles, then busy=0 and req_ready=1.
  - A read of addr 0xFF returns 0x00000000 with rsp_err=0.
- Write addr 0x10 data 0xDEADBEEF be=4'hF, then write 0x10 data 0x11223344 be=4'b0101, then read 0x10:
  - Returns 0xDE22BE44 one cycle after accept.
- Read 0x10 with rsp_ready held low for 4 cycles:
  - rsp_valid and rsp_rdata are stable, and req_ready=0.
  - Raising rsp_ready completes the handshake, and a read accepted in that same cycle reloads the response.
- With DEPTH=200, ADDR_W=8:
  - Write 0xC8 data 0x5 is dropped.
  - Read 0xC8 gives rsp_rdata=0, rsp_err=1.
- Pulse clr together with req_valid while 0x10 holds 0x11111111:
  - The request is not accepted, busy=1 for DEPTH cycles, and 0x10 then reads 0.
- With CALC_MEM_PARITY_EN: write 0x20 data 0x1 with err_inject=1, then read 0x20:
  - rsp_rdata=0x00000001, rsp_err=1.
  - Without the macro, the same sequence gives rsp_err=0.
